// File: rtl/frame_receiver_if.sv
// rtl/frame_receiver_if.sv - signal bundle between the MAC RX client side and frame_receiver
//
// Purpose: groups the MAC receive byte stream, the MAC RX configuration
//   straps and the extracted ARP fields into one interface.
// Modports:
//   slave  - frame_receiver view: consumes mac_rx_*, drives conf_rx_* and ARP results
//   master - MAC / environment view: drives mac_rx_*, observes everything else
// Signals:
//   mac_rx_data[7:0]      received byte, valid while mac_rx_dvld=1
//   mac_rx_dvld           data valid, high for the whole frame without gaps
//   mac_rx_goodframe      one-cycle pulse, previous frame passed MAC checks
//   mac_rx_badframe       one-cycle pulse, previous frame failed MAC checks
//   conf_rx_en            MAC RX enable
//   conf_rx_jumbo_en      MAC jumbo enable (tied 0)
//   conf_rx_no_chk_crc    MAC CRC-check bypass (tied 0)
//   arp_valid             one-cycle pulse, new ARP fields published
//   arp_opcode[15:0]      ARP opcode
//   arp_src_mac[47:0]     sender hardware address
//   arp_src_ip[31:0]      sender protocol address
//   frame_len[13:0]       byte count of the last accepted frame
//   stat_good_cnt[15:0]   published-frame counter (FRAME_RECEIVER_STATS_EN only)
//   stat_drop_cnt[15:0]   discarded-frame counter (FRAME_RECEIVER_STATS_EN only)
// Optional feature macro: FRAME_RECEIVER_STATS_EN

interface frame_receiver_if;
  logic [7:0]  mac_rx_data;
  logic        mac_rx_dvld;
  logic        mac_rx_goodframe;
  logic        mac_rx_badframe;
  logic        conf_rx_en;
  logic        conf_rx_jumbo_en;
  logic        conf_rx_no_chk_crc;
  logic        arp_valid;
  logic [15:0] arp_opcode;
  logic [47:0] arp_src_mac;
  logic [31:0] arp_src_ip;
  logic [13:0] frame_len;
`ifdef FRAME_RECEIVER_STATS_EN
  logic [15:0] stat_good_cnt;
  logic [15:0] stat_drop_cnt;
`endif

  modport slave (
    input  mac_rx_data,
    input  mac_rx_dvld,
    input  mac_rx_goodframe,
    input  mac_rx_badframe,
`ifdef FRAME_RECEIVER_STATS_EN
    output stat_good_cnt,
    output stat_drop_cnt,
`endif
    output conf_rx_en,
    output conf_rx_jumbo_en,
    output conf_rx_no_chk_crc,
    output arp_valid,
    output arp_opcode,
    output arp_src_mac,
    output arp_src_ip,
    output frame_len
  );

  modport master (
    output mac_rx_data,
    output mac_rx_dvld,
    output mac_rx_goodframe,
    output mac_rx_badframe,
`ifdef FRAME_RECEIVER_STATS_EN
    input  stat_good_cnt,
    input  stat_drop_cnt,
`endif
    input  conf_rx_en,
    input  conf_rx_jumbo_en,
    input  conf_rx_no_chk_crc,
    input  arp_valid,
    input  arp_opcode,
    input  arp_src_mac,
    input  arp_src_ip,
    input  frame_len
  );
endinterface

// File: rtl/frame_receiver.sv
// rtl/frame_receiver.sv - ARP frame filter and field extractor on the MAC RX client stream
//
// Purpose: accepts frames addressed to OWN_MAC or broadcast carrying an
//   Ethernet/IPv4 ARP header, captures opcode and sender MAC/IP into shadow
//   registers, and publishes them with a one-cycle arp_valid pulse once the
//   MAC confirms the frame with mac_rx_goodframe.
// Parameters:
//   OWN_MAC      station address accepted as destination
//   STAT_TIMEOUT max cycles in STATUS waiting for a good/bad pulse
// Ports:
//   rx_clk  in  receive clock, rising edge
//   reset   in  asynchronous active-high reset
//   rx_if   frame_receiver_if.slave (MAC RX stream in, conf straps and ARP fields out)
// Optional feature macro: FRAME_RECEIVER_STATS_EN (adds stat_good_cnt / stat_drop_cnt)

module frame_receiver #(
  parameter logic [47:0] OWN_MAC      = 48'h004e46324301,
  parameter int          STAT_TIMEOUT = 16
) (
  input  logic            rx_clk,
  input  logic            reset,
  frame_receiver_if.slave rx_if
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_HDR    = 2'd1,
    S_DROP   = 2'd2,
    S_STATUS = 2'd3
  } state_e;

  localparam int          TW      = $clog2(STAT_TIMEOUT + 1);
  localparam logic [13:0] CNT_MAX = 14'h3FFF;
  localparam logic [13:0] MIN_LEN = 14'd42;

  // Inputs
  logic [7:0] data;
  logic       dvld;
  logic       good;
  logic       bad;

  assign data = rx_if.mac_rx_data;
  assign dvld = rx_if.mac_rx_dvld;
  assign good = rx_if.mac_rx_goodframe;
  assign bad  = rx_if.mac_rx_badframe;

  // State
  state_e        state_q, state_d;
  logic [13:0]   cnt_q, cnt_d;
  logic          own_ok_q, own_ok_d;
  logic          bc_ok_q, bc_ok_d;
  logic [95:0]   shadow_q, shadow_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          conf_rx_en_q;
  logic          arp_valid_q, arp_valid_d;
  logic [15:0]   arp_opcode_q, arp_opcode_d;
  logic [47:0]   arp_src_mac_q, arp_src_mac_d;
  logic [31:0]   arp_src_ip_q, arp_src_ip_d;
  logic [13:0]   frame_len_q, frame_len_d;

  // Decode
  logic        start;
  logic [13:0] byte_idx;
  logic        own_prev, bc_prev, own_now, bc_now;
  logic        byte_bad;
  logic        len_ok;
  logic        tmo_last;
  logic        take_byte;
  logic        publish;
  logic        drop_evt;

  function automatic logic [7:0] own_byte(input logic [2:0] i);
    case (i)
      3'd0:    own_byte = OWN_MAC[47:40];
      3'd1:    own_byte = OWN_MAC[39:32];
      3'd2:    own_byte = OWN_MAC[31:24];
      3'd3:    own_byte = OWN_MAC[23:16];
      3'd4:    own_byte = OWN_MAC[15:8];
      default: own_byte = OWN_MAC[7:0];
    endcase
  endfunction

  // A new frame begins whenever data arrives in IDLE, or in STATUS where it
  // pre-empts the frame still waiting for its MAC status.
  assign start    = dvld && ((state_q == S_IDLE) || (state_q == S_STATUS));
  assign byte_idx = start ? 14'd0 : cnt_q;
  assign len_ok   = (cnt_q >= MIN_LEN);
  assign tmo_last = (tmo_q == TW'(STAT_TIMEOUT - 1));

  // Destination is tracked as two running matches (own / broadcast) so a
  // mix like own-prefix + FF tail is rejected.
  always_comb begin
    own_prev = start ? 1'b1 : own_ok_q;
    bc_prev  = start ? 1'b1 : bc_ok_q;
    own_now  = own_prev && (data == own_byte(byte_idx[2:0]));
    bc_now   = bc_prev && (data == 8'hFF);
    byte_bad = 1'b0;
    case (byte_idx)
      14'd0, 14'd1, 14'd2,
      14'd3, 14'd4, 14'd5: byte_bad = !own_now && !bc_now;
      14'd12:              byte_bad = (data != 8'h08);
      14'd13:              byte_bad = (data != 8'h06);
      14'd14:              byte_bad = (data != 8'h00);
      14'd15:              byte_bad = (data != 8'h01);
      14'd16:              byte_bad = (data != 8'h08);
      14'd17:              byte_bad = (data != 8'h00);
      14'd18:              byte_bad = (data != 8'h06);
      14'd19:              byte_bad = (data != 8'h04);
      default:             byte_bad = 1'b0;
    endcase
  end

  // FSM: state register
  always_ff @(posedge rx_clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (dvld) state_d = byte_bad ? S_DROP : S_HDR;
      end
      S_HDR: begin
        if (dvld) begin
          if (byte_bad) state_d = S_DROP;
        end else begin
          state_d = len_ok ? S_STATUS : S_DROP;
        end
      end
      S_DROP: begin
        if (!dvld) state_d = S_IDLE;
      end
      S_STATUS: begin
        if (dvld) begin
          state_d = byte_bad ? S_DROP : S_HDR;
        end else if (bad || good || tmo_last) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM: outputs. Bad wins over good when both pulse together; new data
  // in STATUS wins over either pulse.
  always_comb begin
    take_byte = 1'b0;
    publish   = 1'b0;
    drop_evt  = 1'b0;
    case (state_q)
      S_IDLE: take_byte = dvld;
      S_HDR:  take_byte = dvld;
      S_DROP: drop_evt  = !dvld;
      S_STATUS: begin
        take_byte = dvld;
        publish   = !dvld && good && !bad;
        drop_evt  = dvld || bad || (!good && tmo_last);
      end
      default: ;
    endcase
  end

  // Datapath next state
  always_comb begin
    cnt_d = cnt_q;
    if (start) begin
      cnt_d = 14'd1;
    end else if (take_byte && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 14'd1;
    end

    own_ok_d = own_ok_q;
    bc_ok_d  = bc_ok_q;
    if (take_byte && (byte_idx < 14'd6)) begin
      own_ok_d = own_now;
      bc_ok_d  = bc_now;
    end

    // Bytes 20..31 shift in MSB-first: opcode ends up in [95:80],
    // sender MAC in [79:32], sender IP in [31:0].
    shadow_d = shadow_q;
    if (take_byte && (byte_idx >= 14'd20) && (byte_idx <= 14'd31)) begin
      shadow_d = {shadow_q[87:0], data};
    end

    tmo_d = ((state_q == S_STATUS) && !dvld) ? tmo_q + 1'b1 : '0;

    arp_valid_d   = publish;
    arp_opcode_d  = publish ? shadow_q[95:80] : arp_opcode_q;
    arp_src_mac_d = publish ? shadow_q[79:32] : arp_src_mac_q;
    arp_src_ip_d  = publish ? shadow_q[31:0]  : arp_src_ip_q;
    frame_len_d   = publish ? cnt_q           : frame_len_q;
  end

  // Datapath registers
  always_ff @(posedge rx_clk or posedge reset) begin
    if (reset) begin
      cnt_q         <= '0;
      own_ok_q      <= 1'b0;
      bc_ok_q       <= 1'b0;
      shadow_q      <= '0;
      tmo_q         <= '0;
      conf_rx_en_q  <= 1'b0;
      arp_valid_q   <= 1'b0;
      arp_opcode_q  <= '0;
      arp_src_mac_q <= '0;
      arp_src_ip_q  <= '0;
      frame_len_q   <= '0;
    end else begin
      cnt_q         <= cnt_d;
      own_ok_q      <= own_ok_d;
      bc_ok_q       <= bc_ok_d;
      shadow_q      <= shadow_d;
      tmo_q         <= tmo_d;
      conf_rx_en_q  <= 1'b1;
      arp_valid_q   <= arp_valid_d;
      arp_opcode_q  <= arp_opcode_d;
      arp_src_mac_q <= arp_src_mac_d;
      arp_src_ip_q  <= arp_src_ip_d;
      frame_len_q   <= frame_len_d;
    end
  end

  assign rx_if.conf_rx_en         = conf_rx_en_q;
  assign rx_if.conf_rx_jumbo_en   = 1'b0;
  assign rx_if.conf_rx_no_chk_crc = 1'b0;
  assign rx_if.arp_valid          = arp_valid_q;
  assign rx_if.arp_opcode         = arp_opcode_q;
  assign rx_if.arp_src_mac        = arp_src_mac_q;
  assign rx_if.arp_src_ip         = arp_src_ip_q;
  assign rx_if.frame_len          = frame_len_q;

`ifdef FRAME_RECEIVER_STATS_EN
  logic [15:0] good_cnt_q, good_cnt_d;
  logic [15:0] drop_cnt_q, drop_cnt_d;

  // Both counters wrap naturally at 16'hFFFF.
  assign good_cnt_d = publish  ? good_cnt_q + 16'd1 : good_cnt_q;
  assign drop_cnt_d = drop_evt ? drop_cnt_q + 16'd1 : drop_cnt_q;

  always_ff @(posedge rx_clk or posedge reset) begin
    if (reset) begin
      good_cnt_q <= '0;
      drop_cnt_q <= '0;
    end else begin
      good_cnt_q <= good_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign rx_if.stat_good_cnt = good_cnt_q;
  assign rx_if.stat_drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_frame_receiver.sv
// tb/tb_frame_receiver.sv - self-checking bench for frame_receiver with a frame-level reference model

module tb_frame_receiver;

  localparam logic [47:0] OWN   = 48'h004e46324301;
  localparam logic [47:0] BCAST = 48'hFFFFFFFFFFFF;
  localparam int          TMO   = 16;

  logic rx_clk = 1'b0;
  logic reset  = 1'b1;
  always #5 rx_clk = ~rx_clk;

  frame_receiver_if bus ();

  frame_receiver #(.OWN_MAC(OWN), .STAT_TIMEOUT(TMO)) dut (
    .rx_clk (rx_clk),
    .reset  (reset),
    .rx_if  (bus)
  );

  int errors = 0;
  int checks = 0;
  int pulses = 0;
  int exp_pulses = 0;

  logic [15:0] exp_op   = '0;
  logic [47:0] exp_mac  = '0;
  logic [31:0] exp_ip   = '0;
  logic [13:0] exp_len  = '0;
  logic [15:0] exp_good = '0;
  logic [15:0] exp_drop = '0;

  logic [7:0] frm[$];

  always @(negedge rx_clk) if (bus.arp_valid === 1'b1) pulses++;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic build(input logic [47:0] dst, input logic [15:0] etype, input logic [15:0] op,
                       input logic [47:0] smac, input logic [31:0] sip, input int len);
    logic [7:0] hdr[$];
    hdr = {};
    for (int i = 5; i >= 0; i--) hdr.push_back(dst[8*i +: 8]);
    for (int i = 5; i >= 0; i--) hdr.push_back(smac[8*i +: 8]);
    hdr.push_back(etype[15:8]); hdr.push_back(etype[7:0]);
    hdr.push_back(8'h00); hdr.push_back(8'h01);
    hdr.push_back(8'h08); hdr.push_back(8'h00);
    hdr.push_back(8'h06); hdr.push_back(8'h04);
    hdr.push_back(op[15:8]); hdr.push_back(op[7:0]);
    for (int i = 5; i >= 0; i--) hdr.push_back(smac[8*i +: 8]);
    for (int i = 3; i >= 0; i--) hdr.push_back(sip[8*i +: 8]);
    for (int i = 0; i < 10; i++) hdr.push_back(8'h00);
    frm = {};
    for (int i = 0; i < len; i++) frm.push_back(i < hdr.size() ? hdr[i] : 8'($urandom));
  endtask

  // Frame-level rule: published iff address/header rules hold, length >= 42,
  // and a good-only status pulse lands 1..TMO cycles after data ends.
  function automatic bit model_publish(input int k, input bit good, input bit bad);
    logic [47:0] dst;
    bit ok;
    dst = '0;
    for (int i = 0; i < 6; i++) dst = {dst[39:0], frm[i]};
    ok = (frm.size() >= 42) && ((dst == OWN) || (dst == BCAST)) &&
         (frm[12] == 8'h08) && (frm[13] == 8'h06) && (frm[14] == 8'h00) && (frm[15] == 8'h01) &&
         (frm[16] == 8'h08) && (frm[17] == 8'h00) && (frm[18] == 8'h06) && (frm[19] == 8'h04);
    return ok && good && !bad && (k >= 1) && (k <= TMO);
  endfunction

  task automatic expect_frame(input bit pub);
    if (pub) begin
      exp_op  = {frm[20], frm[21]};
      exp_mac = {frm[22], frm[23], frm[24], frm[25], frm[26], frm[27]};
      exp_ip  = {frm[28], frm[29], frm[30], frm[31]};
      exp_len = 14'(frm.size());
      exp_pulses++;
      exp_good++;
    end else begin
      exp_drop++;
    end
  endtask

  task automatic drive_bytes();
    foreach (frm[i]) begin
      @(negedge rx_clk);
      bus.mac_rx_dvld = 1'b1;
      bus.mac_rx_data = frm[i];
    end
    @(negedge rx_clk);
    bus.mac_rx_dvld = 1'b0;
    bus.mac_rx_data = 8'h00;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, " pulses"}, pulses, exp_pulses);
    chk({tag, " valid_idle"}, bus.arp_valid, 1'b0);
    chk({tag, " opcode"}, bus.arp_opcode, exp_op);
    chk({tag, " src_mac"}, bus.arp_src_mac, exp_mac);
    chk({tag, " src_ip"}, bus.arp_src_ip, exp_ip);
    chk({tag, " frame_len"}, bus.frame_len, exp_len);
`ifdef FRAME_RECEIVER_STATS_EN
    chk({tag, " good_cnt"}, bus.stat_good_cnt, exp_good);
    chk({tag, " drop_cnt"}, bus.stat_drop_cnt, exp_drop);
`endif
  endtask

  // k = cycles from the first dvld-low edge to the edge sampling the pulse.
  task automatic status_and_check(input string tag, input int k, input bit good, input bit bad,
                                  input bit pub);
    if (good || bad) begin
      repeat (k) @(negedge rx_clk);
      bus.mac_rx_goodframe = good;
      bus.mac_rx_badframe  = bad;
      @(negedge rx_clk);
      bus.mac_rx_goodframe = 1'b0;
      bus.mac_rx_badframe  = 1'b0;
      expect_frame(pub);
      chk({tag, " valid"}, bus.arp_valid, pub);
    end else begin
      expect_frame(pub);
    end
    repeat (TMO + 4) @(negedge rx_clk);
    check_outputs(tag);
  endtask

  task automatic run_frame(input string tag, input int k, input bit good, input bit bad);
    bit pub;
    pub = model_publish(k, good, bad);
    drive_bytes();
    status_and_check(tag, k, good, bad, pub);
  endtask

  initial begin
    bus.mac_rx_data      = 8'h00;
    bus.mac_rx_dvld      = 1'b0;
    bus.mac_rx_goodframe = 1'b0;
    bus.mac_rx_badframe  = 1'b0;

    // Reset state
    repeat (2) @(negedge rx_clk);
    chk("rst conf_rx_en", bus.conf_rx_en, 1'b0);
    check_outputs("rst");
    chk("rst jumbo", bus.conf_rx_jumbo_en, 1'b0);
    chk("rst no_chk_crc", bus.conf_rx_no_chk_crc, 1'b0);
    reset = 1'b0;
    @(negedge rx_clk);
    chk("conf_rx_en up", bus.conf_rx_en, 1'b1);

    // 1: broadcast request, explicit expected fields
    build(BCAST, 16'h0806, 16'h0001, 48'h0022FA157ADA, 32'hCBB28BD5, 60);
    run_frame("t1", 2, 1'b1, 1'b0);
    chk("t1 const opcode", bus.arp_opcode, 16'h0001);
    chk("t1 const mac", bus.arp_src_mac, 48'h0022FA157ADA);
    chk("t1 const ip", bus.arp_src_ip, 32'hCBB28BD5);
    chk("t1 const len", bus.frame_len, 14'd60);

    // 2: near-miss destination
    build(48'h004E46324300, 16'h0806, 16'h0002, 48'h112233445566, 32'h0A000001, 60);
    run_frame("t2", 2, 1'b1, 1'b0);

    // 3: wrong EtherType, then a runt
    build(OWN, 16'h0800, 16'h0002, 48'h112233445566, 32'h0A000001, 60);
    run_frame("t3a", 2, 1'b1, 1'b0);
    build(OWN, 16'h0806, 16'h0002, 48'h112233445566, 32'h0A000001, 30);
    run_frame("t3b", 2, 1'b1, 1'b0);

    // 4: badframe, no status, both pulses, timeout boundary
    build(OWN, 16'h0806, 16'h0002, 48'hA1A2A3A4A5A6, 32'hC0A80101, 60);
    run_frame("t4a", 2, 1'b0, 1'b1);
    run_frame("t4b", 0, 1'b0, 1'b0);
    run_frame("t4c", 3, 1'b1, 1'b1);
    run_frame("t4d", TMO, 1'b1, 1'b0);
    build(BCAST, 16'h0806, 16'h0001, 48'hB1B2B3B4B5B6, 32'hC0A80102, 64);
    run_frame("t4e", TMO + 1, 1'b1, 1'b0);

    // Length boundary: 41 is a runt, 42 is accepted; own address accepted
    build(OWN, 16'h0806, 16'h0001, 48'hC1C2C3C4C5C6, 32'h01020304, 41);
    run_frame("len41", 1, 1'b1, 1'b0);
    build(OWN, 16'h0806, 16'h0001, 48'hD1D2D3D4D5D6, 32'h05060708, 42);
    run_frame("len42", 1, 1'b1, 1'b0);

    // 5: reset at byte 25
    build(BCAST, 16'h0806, 16'h0002, 48'hE1E2E3E4E5E6, 32'h090A0B0C, 60);
    for (int i = 0; i < 25; i++) begin
      @(negedge rx_clk);
      bus.mac_rx_dvld = 1'b1;
      bus.mac_rx_data = frm[i];
    end
    @(negedge rx_clk);
    reset = 1'b1;
    bus.mac_rx_dvld = 1'b0;
    bus.mac_rx_data = 8'h00;
    #1;
    exp_op = '0; exp_mac = '0; exp_ip = '0; exp_len = '0; exp_good = '0; exp_drop = '0;
    chk("t5 conf_rx_en", bus.conf_rx_en, 1'b0);
    check_outputs("t5 rst");
    repeat (2) @(negedge rx_clk);
    reset = 1'b0;
    @(negedge rx_clk);
    chk("t5 conf_rx_en up", bus.conf_rx_en, 1'b1);
    build(OWN, 16'h0806, 16'h0002, 48'hF1F2F3F4F5F6, 32'h0D0E0F10, 48);
    run_frame("t5 next", 4, 1'b1, 1'b0);

    // 6: second frame pre-empts the first while it waits for status
    begin
      bit pub2;
      build(OWN, 16'h0806, 16'h0001, 48'h0A0B0C0D0E0F, 32'h11111111, 50);
      drive_bytes();
      exp_drop++;
      build(BCAST, 16'h0806, 16'h0002, 48'h505152535455, 32'h22222222, 55);
      pub2 = model_publish(2, 1'b1, 1'b0);
      drive_bytes();
      status_and_check("t6", 2, 1'b1, 1'b0, pub2);
      chk("t6 const mac", bus.arp_src_mac, 48'h505152535455);
    end

    // Randomized frames against the model
    for (int n = 0; n < 30; n++) begin
      int sel, len, k, mode;
      logic [47:0] dst;
      logic [15:0] et;
      sel = $urandom_range(0, 3);
      case (sel)
        0:       dst = OWN;
        1:       dst = BCAST;
        2:       dst = 48'({$urandom(), $urandom()});
        default: dst = {OWN[47:8], 8'($urandom)};
      endcase
      et  = ($urandom_range(0, 4) == 0) ? 16'($urandom) : 16'h0806;
      len = $urandom_range(36, 72);
      build(dst, et, 16'($urandom), 48'({$urandom(), $urandom()}), 32'($urandom), len);
      if ($urandom_range(0, 5) == 0) begin
        int idx;
        idx = $urandom_range(12, 19);
        frm[idx] = frm[idx] ^ 8'($urandom_range(1, 255));
      end
      k    = $urandom_range(1, 18);
      mode = $urandom_range(0, 5);
      case (mode)
        0, 1, 2: run_frame($sformatf("rnd%0d", n), k, 1'b1, 1'b0);
        3:       run_frame($sformatf("rnd%0d", n), k, 1'b0, 1'b1);
        4:       run_frame($sformatf("rnd%0d", n), k, 1'b1, 1'b1);
        default: run_frame($sformatf("rnd%0d", n), 0, 1'b0, 1'b0);
      endcase
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
